// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, message-locked arbiter sharing one UART transmitter stream among NUM_PORTS AXI-Stream requesters
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axis_tdata      requester data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid     per-requester valid
//   s_axis_tlast      per-requester end-of-message
//   s_axis_tready     per-requester ready (only the owner's bit can be high)
//   m_axis_tdata/tvalid/tready  stream to the shared transmitter
//   grant             one-hot current owner, zero when idle
//   busy              high while a requester owns the transmitter
// Optional: define UART_TX_ARB_TIMEOUT_EN to force a lock release after TIMEOUT_CYCLES cycles without a transfer.
module uart_tx_arb #(
   parameter int NUM_PORTS      = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [NUM_PORTS-1:0]            grant,
   output logic                            busy
);
   localparam int IW = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state, state_nx;
   logic [IW-1:0]        owner, owner_nx, pick, idx;
   logic [NUM_PORTS-1:0] grant_nx;
   logic                 xfer, timeout;

   if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_arb: unsupported parameter values");
   end

   // owner holds the current owner while LOCKED and the last owner while IDLE
   assign busy          = state == LOCKED;
   assign m_axis_tdata  = s_axis_tdata[owner*DATA_WIDTH +: DATA_WIDTH];
   assign m_axis_tvalid = busy & s_axis_tvalid[owner];
   assign s_axis_tready = grant & {NUM_PORTS{m_axis_tready}};
   assign xfer          = m_axis_tvalid & m_axis_tready;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] idle_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) idle_cnt <= '0;
      else        idle_cnt <= (busy && !xfer && !timeout) ? idle_cnt + 1'b1 : '0;
   assign timeout = busy && !xfer && idle_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif

   // scan downwards so the nearest valid port after the last owner wins
   always_comb begin
      pick = owner;
      idx  = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = IW'((int'(owner) + i) % NUM_PORTS);
         if (s_axis_tvalid[idx]) pick = idx;
      end
   end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      grant_nx = grant;
      if (state == IDLE) begin
         if (|s_axis_tvalid) begin
            state_nx = LOCKED;
            owner_nx = pick;
            grant_nx = NUM_PORTS'(1) << pick;
         end
      end else if ((xfer && s_axis_tlast[owner]) || timeout) begin
         state_nx = IDLE;
         grant_nx = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         owner <= IW'(NUM_PORTS - 1);
         grant <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         grant <= grant_nx;
      end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb (4 ports, 8-bit data, TIMEOUT_CYCLES=16)
module tb_uart_tx_arb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] tdata = '0;
   logic [3:0]  tvalid = '0;
   logic [3:0]  tlast = '0;
   logic [3:0]  tready, grant;
   logic [7:0]  m_tdata;
   logic        m_tvalid, busy;
   logic        m_tready = 1'b1;
   int          tests = 0;
   int          fails = 0;
   logic [7:0]  beats[$];

   always #5 clk = ~clk;

   uart_tx_arb #(.NUM_PORTS(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .grant(grant), .busy(busy)
   );

   // inputs only change just after posedge, so the negedge view equals what the next edge sees
   always @(negedge clk) if (rst_n && m_tvalid && m_tready) beats.push_back(m_tdata);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic [7:0] d, input logic v, input logic l);
      tdata[p*8 +: 8] = d;
      tvalid[p] = v;
      tlast[p] = l;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_tready", tready, 0);
      tick; tick;
      rst_n = 1'b1;
      // single requester, three-beat message
      drive(2, 8'h41, 1, 0); #1;
      chk("idle_mvalid", m_tvalid, 0);
      chk("idle_tready", tready, 0);
      tick;
      chk("t1_grant", grant, 4'b0100);
      chk("t1_busy", busy, 1);
      chk("t1_d0", m_tdata, 8'h41);
      chk("t1_tready", tready, 4'b0100);
      tick; drive(2, 8'h42, 1, 0); #1;
      chk("t1_d1", m_tdata, 8'h42);
      tick; drive(2, 8'h43, 1, 1); #1;
      chk("t1_d2", m_tdata, 8'h43);
      tick; drive(2, 8'h00, 0, 0);
      chk("t1_release", grant, 0);
      chk("t1_busy_off", busy, 0);
      chk("t1_nbeats", beats.size(), 3);
      chk("t1_b0", beats[0], 8'h41);
      chk("t1_b1", beats[1], 8'h42);
      chk("t1_b2", beats[2], 8'h43);
      beats.delete();
      // fresh reset, all ports request one-beat messages
      rst_n = 1'b0; #2; rst_n = 1'b1;
      for (int p = 0; p < 4; p++) drive(p, 8'hB0 + 8'(p), 1, 1);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t2_grant", grant, 4'b0001 << (i % 4));
         chk("t2_data", m_tdata, 8'hB0 + (i % 4));
         tick;
         chk("t2_idle", grant, 0);
      end
      tvalid = '0; tlast = '0;
      beats.delete();
      // owner stalls mid-message while port 3 waits
      drive(1, 8'h10, 1, 0);
      drive(3, 8'h33, 1, 1);
      tick;
      chk("t3_grant", grant, 4'b0010);
      chk("t3_d0", m_tdata, 8'h10);
      tick; drive(1, 8'h10, 0, 0); #1;
      repeat (20) begin
         chk("t3_rdy3", tready[3], 0);
         chk("t3_hold", grant, 4'b0010);
         chk("t3_mvalid", m_tvalid, 0);
         tick;
      end
      drive(1, 8'h11, 1, 1); #1;
      chk("t3_d1", m_tdata, 8'h11);
      chk("t3_tready", tready, 4'b0010);
      tick; drive(1, 8'h00, 0, 0);
      chk("t3_release", grant, 0);
      chk("t3_nbeats", beats.size(), 2);
      chk("t3_b1", beats[1], 8'h11);
      tick;
      chk("t3_grant3", grant, 4'b1000);
      chk("t3_d3", m_tdata, 8'h33);
      tick; drive(3, 8'h00, 0, 0);
      chk("t3_done", grant, 0);
      beats.delete();
      // downstream ready toggling 1,0,1,0,1
      drive(0, 8'hA0, 1, 0);
      tick;
      chk("t4_grant", grant, 4'b0001);
      chk("t4_rdy_hi", tready, 4'b0001);
      tick; drive(0, 8'hA1, 1, 0); m_tready = 1'b0; #1;
      chk("t4_rdy_lo", tready, 0);
      chk("t4_mvalid", m_tvalid, 1);
      chk("t4_d1", m_tdata, 8'hA1);
      tick; m_tready = 1'b1; #1;
      chk("t4_d1_hold", m_tdata, 8'hA1);
      tick; drive(0, 8'hA2, 1, 1); m_tready = 1'b0; #1;
      chk("t4_busy_a", busy, 1);
      tick;
      chk("t4_busy_b", busy, 1);
      m_tready = 1'b1;
      tick;
      chk("t4_release", grant, 0);
      chk("t4_busy_off", busy, 0);
      drive(0, 8'h00, 0, 0);
      chk("t4_nbeats", beats.size(), 3);
      chk("t4_b0", beats[0], 8'hA0);
      chk("t4_b1", beats[1], 8'hA1);
      chk("t4_b2", beats[2], 8'hA2);
      beats.delete();
      // reset during the second beat
      drive(0, 8'h50, 1, 0);
      tick;
      chk("t5_grant", grant, 4'b0001);
      tick; drive(0, 8'h51, 1, 0); #1;
      chk("t5_d1", m_tdata, 8'h51);
      #2; rst_n = 1'b0; #1;
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_mvalid", m_tvalid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_tready", tready, 0);
      drive(0, 8'h60, 1, 1);
      drive(2, 8'h62, 1, 1);
      tick; rst_n = 1'b1;
      tick;
      chk("t5_first", grant, 4'b0001);
      chk("t5_d60", m_tdata, 8'h60);
      tick; drive(0, 8'h00, 0, 0);
      chk("t5_idle", grant, 0);
      tick;
      chk("t5_second", grant, 4'b0100);
      tick; drive(2, 8'h00, 0, 0);
      chk("t5_done", grant, 0);
      // owner goes silent without tlast while port 1 waits
      drive(0, 8'h70, 1, 0);
      drive(1, 8'h71, 1, 1);
      tick;
      chk("t6_grant", grant, 4'b0001);
      tick; drive(0, 8'h00, 0, 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      repeat (15) begin
         tick;
         chk("t6_hold", grant, 4'b0001);
      end
      tick;
`else
      repeat (25) begin
         tick;
         chk("t6_hold", grant, 4'b0001);
      end
      drive(0, 8'h72, 1, 1);
      tick; drive(0, 8'h00, 0, 0);
`endif
      chk("t6_release", grant, 0);
      chk("t6_busy_off", busy, 0);
      tick;
      chk("t6_grant1", grant, 4'b0010);
      chk("t6_d71", m_tdata, 8'h71);
      tick; drive(1, 8'h00, 0, 0);
      chk("t6_done", grant, 0);
      chk("t6_mvalid", m_tvalid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
